// File: rtl/seq_detect_pkg.sv
// Shared definitions for the sequence-detector controller: FSM state
// encodings, default parameter values and a small sizing helper.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    // Width of the fill counter, which only ever needs to reach pat_w-1.
    function automatic int fill_width(input int pat_w);
        return (pat_w <= 2) ? 1 : $clog2(pat_w);
    endfunction

endpackage

// File: rtl/pattern_matcher.sv
// Serial pattern matcher: keeps the last PAT_W-1 accepted bits and a
// saturating fill count, and flags when the incoming bit completes the
// programmed pattern. History is wiped on a match when overlap is off.
module pattern_matcher
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int                FILL_W   = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  history_reg, history_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  bit_eq;

    // Oldest bit sits in the MSB, the bit arriving this cycle in the LSB.
    assign window = {history_reg, bit_in};

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = ~(window[gi] ^ pattern[gi]);
        end
    endgenerate

    // A match needs a full history plus the current bit to line up.
    assign match = (fill_reg == FILL_MAX) && (&bit_eq);

    // Next history/fill: clear on reconfiguration or non-overlapping match,
    // otherwise shift in the accepted bit and saturate fill.
    always_comb begin
        history_next = history_reg;
        fill_next    = fill_reg;
        if (clear) begin
            history_next = '0;
            fill_next    = '0;
        end else if (shift_en) begin
            if (match && !overlap) begin
                history_next = '0;
                fill_next    = '0;
            end else begin
                history_next = window[PAT_W-2:0];
                fill_next    = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + 1'b1;
            end
        end
    end

    // History and fill registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            history_reg <= '0;
            fill_reg    <= '0;
        end else begin
            history_reg <= history_next;
            fill_reg    <= fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable sequence-detector controller: configuration handshake,
// IDLE/RUN/DONE FSM, match gating and the saturating match counter.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [PAT_W-1:0] pattern_reg;
    logic             overlap_reg;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] count_reg, count_next, count_inc;

    logic accept;
    logic bit_take;
    logic match_raw;
    logic target_hit;

    assign accept   = cfg_valid & cfg_ready;
    // Only bits seen while running and not aborting reach the matcher.
    assign bit_take = (state_reg == ST_RUN) & bit_valid & ~abort;

    pattern_matcher #(
        .PAT_W (PAT_W)
    ) u_matcher (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .shift_en (bit_take),
        .bit_in   (bit_in),
        .pattern  (pattern_reg),
        .overlap  (overlap_reg),
        .match    (match_raw)
    );

    assign count_inc  = count_reg + 1'b1;
    // The match that brings the count up to a non-zero target ends the run.
    assign target_hit = z && (target_reg != '0) && (count_inc == target_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a handshake accepted in DONE wins over abort.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort)           state_next = ST_IDLE;
                else if (target_hit) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (accept)     state_next = ST_RUN;
                else if (abort) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state plus the Mealy match flag.
    always_comb begin
        cfg_ready = (state_reg != ST_RUN);
        busy      = (state_reg == ST_RUN);
        done      = (state_reg == ST_DONE);
        z         = bit_take & match_raw;
    end

    // Counter next value: cleared by a new configuration, saturating otherwise.
    always_comb begin
        count_next = count_reg;
        if (accept) begin
            count_next = '0;
        end else if (z && !(&count_reg)) begin
            count_next = count_inc;
        end
    end

    // Configuration latches and match counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pattern_reg <= '0;
            overlap_reg <= 1'b0;
            target_reg  <= '0;
            count_reg   <= '0;
        end else begin
            if (accept) begin
                pattern_reg <= cfg_pattern;
                overlap_reg <= cfg_overlap;
                target_reg  <= cfg_target;
            end
            count_reg <= count_next;
        end
    end

    assign match_count = count_reg;

endmodule
